// File: rtl/dm_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder_if
// Description : Request/response bundle between the CPU M-stage and the
//               data-memory responder.
// Revision    : 1.0
// ============================================================================
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_byteen, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_byteen, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Data-memory responder with LATENCY wait cycles, byte-enabled
//               word stores and word loads. Store tracing: DM_RESPONDER_TRACE_EN.
// Revision    : 1.0
// ============================================================================
module dm_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus
);

    localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
    localparam int         c_UPW      = 30 - ADDR_WIDTH;
    localparam logic [3:0] c_LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         c_ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [c_UPW-1:0]      r_upper;
    logic [3:0]            r_byteen;
    logic [31:0]           r_wdata;
    logic [31:0]           r_pc;
    logic [31:0]           r_mem [c_DEPTH];
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [31:0]           r_resp_rdata;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_enter_done;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [c_UPW-1:0]      w_upper;
    logic [3:0]            w_byteen;
    logic [31:0]           w_wdata;
    logic [31:0]           w_pc;
    logic                  w_in_range;
    logic [31:0]           w_cur;
    logic [31:0]           w_merged;

    // With zero latency the access happens on the capture edge itself, so
    // operands come straight from the bus while still in IDLE.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_we     = bus.req_we;
            w_idx    = bus.req_addr[ADDR_WIDTH+1:2];
            w_upper  = bus.req_addr[31:ADDR_WIDTH+2];
            w_byteen = bus.req_byteen;
            w_wdata  = bus.req_wdata;
            w_pc     = bus.req_pc;
        end else begin
            w_we     = r_we;
            w_idx    = r_idx;
            w_upper  = r_upper;
            w_byteen = r_byteen;
            w_wdata  = r_wdata;
            w_pc     = r_pc;
        end
    end

    assign w_in_range = (w_upper == '0);
    assign w_cur      = r_mem[w_idx];

    always_comb begin
        w_merged = w_cur;
        for (int i = 0; i < 4; i++) begin
            if (w_byteen[i]) begin
                w_merged[8*i +: 8] = w_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (c_ZERO_LAT) begin
                        w_next       = ST_DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next       = ST_DONE;
                    w_enter_done = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_idx        <= '0;
            r_upper      <= '0;
            r_byteen     <= 4'd0;
            r_wdata      <= 32'd0;
            r_pc         <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_idx    <= bus.req_addr[ADDR_WIDTH+1:2];
                r_upper  <= bus.req_addr[31:ADDR_WIDTH+2];
                r_byteen <= bus.req_byteen;
                r_wdata  <= bus.req_wdata;
                r_pc     <= bus.req_pc;
                r_cnt    <= c_LAT_LOAD;
            end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_done) begin
                if (w_we && w_in_range) begin
                    r_mem[w_idx] <= w_merged;
                end
                r_resp_valid <= 1'b1;
                r_resp_err   <= !w_in_range;
                r_resp_rdata <= !w_in_range ? 32'd0 : (w_we ? w_merged : w_cur);
            end else if (r_state == ST_DONE) begin
                r_resp_valid <= 1'b0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

    logic w_unused_lsb;
    assign w_unused_lsb = ^bus.req_addr[1:0];

`ifdef DM_RESPONDER_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_enter_done && w_we && w_in_range && (w_byteen != 4'd0)) begin
            $display("@%08h: *%08h <= %08h", w_pc,
                     {{c_UPW{1'b0}}, w_idx, 2'b00}, w_merged);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^w_pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// Testbench for dm_responder: a LATENCY=2 instance driven from a vector table,
// plus a LATENCY=0 instance for throughput and a reset-abort sequence.
module tb_dm_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    dm_responder_if bus2();
    dm_responder_if bus0();

    dm_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    dm_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_valid(input bit s);
        return s ? bus0.resp_valid : bus2.resp_valid;
    endfunction

    function automatic logic get_ready(input bit s);
        return s ? bus0.req_ready : bus2.req_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input bit s);
        return s ? bus0.resp_rdata : bus2.resp_rdata;
    endfunction

    function automatic logic get_err(input bit s);
        return s ? bus0.resp_err : bus2.resp_err;
    endfunction

    task automatic drive(input bit s, input logic v, input vec_t t, input logic [31:0] pc);
        if (s) begin
            bus0.req_valid = v; bus0.req_we = t.we; bus0.req_addr = t.addr;
            bus0.req_byteen = t.be; bus0.req_wdata = t.wdata; bus0.req_pc = pc;
        end else begin
            bus2.req_valid = v; bus2.req_we = t.we; bus2.req_addr = t.addr;
            bus2.req_byteen = t.be; bus2.req_wdata = t.wdata; bus2.req_pc = pc;
        end
    endtask

    // Issue one request, measure latency from the capture edge, check response.
    task automatic do_req(input bit s, input vec_t t, input string tag);
        int lat;
        bit got;
        int exp_lat;
        exp_lat = s ? 1 : 3;
        @(negedge clk);
        drive(s, 1'b1, t, 32'h0000_3000);
        @(posedge clk);
        #1;
        chk({tag, "_ready_drop"}, 32'(get_ready(s)), 32'd0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (get_valid(s)) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, get_rdata(s), t.exp_rdata);
        chk({tag, "_err"}, 32'(get_err(s)), 32'(t.exp_err));
        drive(s, 1'b0, t, 32'h0);
    endtask

    vec_t tbl2 [14];
    vec_t tbl0 [4];
    vec_t v;

    initial begin
        bit saw;
        n_checks = 0;
        n_errors = 0;

        tbl2[0]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl2[1]  = '{1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tbl2[2]  = '{1'b1, 32'h0000_0004, 4'h2, 32'h0000_5500, 32'hDEAD_55EF, 1'b0};
        tbl2[3]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0000_0000, 32'hDEAD_55EF, 1'b0};
        tbl2[4]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        tbl2[5]  = '{1'b1, 32'h0001_0000, 4'hF, 32'h1111_1111, 32'h0000_0000, 1'b1};
        tbl2[6]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        tbl2[7]  = '{1'b1, 32'h0000_0006, 4'hC, 32'hABCD_0000, 32'hABCD_55EF, 1'b0};
        tbl2[8]  = '{1'b1, 32'h0000_0004, 4'h0, 32'hFFFF_FFFF, 32'hABCD_55EF, 1'b0};
        tbl2[9]  = '{1'b0, 32'h0000_0007, 4'h0, 32'h0000_0000, 32'hABCD_55EF, 1'b0};
        tbl2[10] = '{1'b1, 32'h0000_3FFC, 4'h5, 32'h0102_0304, 32'h0002_0004, 1'b0};
        tbl2[11] = '{1'b0, 32'h0000_3FFC, 4'h0, 32'h0000_0000, 32'h0002_0004, 1'b0};
        tbl2[12] = '{1'b0, 32'h0000_4000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl2[13] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};

        tbl0[0]  = '{1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tbl0[1]  = '{1'b1, 32'h0000_0004, 4'h2, 32'h0000_5500, 32'hDEAD_55EF, 1'b0};
        tbl0[2]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0000_0000, 32'hDEAD_55EF, 1'b0};
        tbl0[3]  = '{1'b0, 32'h0001_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};

        v = '{1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
        reset = 1'b1;
        drive(1'b0, 1'b0, v, 32'h0);
        drive(1'b1, 1'b0, v, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_ready",  32'(bus2.req_ready), 32'd1);
        chk("rst_valid",  32'(bus2.resp_valid), 32'd0);
        chk("rst_rdata",  bus2.resp_rdata, 32'd0);
        chk("rst_err",    32'(bus2.resp_err), 32'd0);
        chk("rst0_ready", 32'(bus0.req_ready), 32'd1);

        // Zero-latency instance, req_valid held: captures every second edge.
        @(negedge clk);
        drive(1'b1, 1'b1, v, 32'h0000_2000);
        @(posedge clk);
        #1;
        chk("l0_cap1_valid", 32'(bus0.resp_valid), 32'd1);
        chk("l0_cap1_ready", 32'(bus0.req_ready), 32'd0);
        chk("l0_cap1_rdata", bus0.resp_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("l0_idle_valid", 32'(bus0.resp_valid), 32'd0);
        chk("l0_idle_ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("l0_cap2_valid", 32'(bus0.resp_valid), 32'd1);
        chk("l0_cap2_ready", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, v, 32'h0);

        for (int i = 0; i < 14; i++) begin
            do_req(1'b0, tbl2[i], $sformatf("l2_v%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, tbl0[i], $sformatf("l0_v%0d", i));
        end

        // Reset while BUSY aborts the store: no response, no array write.
        v = '{1'b1, 32'h0000_0008, 4'hF, 32'h1234_5678, 32'h0, 1'b0};
        @(negedge clk);
        drive(1'b0, 1'b1, v, 32'h0000_4000);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, v, 32'h0);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b0;
            if (bus2.resp_valid) saw = 1'b1;
        end
        chk("abort_no_resp", 32'(saw), 32'd0);
        chk("abort_ready", 32'(bus2.req_ready), 32'd1);
        v = '{1'b0, 32'h0000_0008, 4'h0, 32'h0, 32'h0000_0000, 1'b0};
        do_req(1'b0, v, "abort_load8");
        v = '{1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'h0000_0000, 1'b0};
        do_req(1'b0, v, "abort_load4");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder (slave side) for the pipelined CPU's M-stage load/store port.
- Accepts one request at a time under a valid/ready handshake and inserts LATENCY wait cycles.
- Performs byte-enabled word writes and word reads on a private word array, then returns a one-cycle response.
- Replaces the internal single-cycle DM when memory is moved outside the core; the CPU stalls until resp_valid.

Parameters:
- ADDR_WIDTH, 12, word-index bits; the array holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles between request capture and the start of the write/read; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; held stable by the CPU until resp_valid.
- req_ready  output  1  responder idle; request is accepted on an edge where req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_byteen  input  4  byte lanes to write; bit i covers wdata[8i+7:8i]; ignored for loads.
- req_wdata  input  32  store data, already lane-aligned by the CPU.
- req_pc  input  32  PC of the issuing instruction; used only for trace.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  word read, or post-merge word for a store.
- resp_err  output  1  address out of range; qualified by resp_valid.

Behaviour:
- States and transitions:
  - IDLE → BUSY, or → DONE when LATENCY = 0.
  - BUSY → DONE after the counter expires.
  - DONE → IDLE.
- Reset: state = IDLE, wait counter = 0, every array word = 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Reset mid-operation aborts the request: no array write, and no resp_valid is issued for that request.
- Capture:
  - In IDLE with req_valid = 1, the edge latches we, word index, upper address bits, byteen, wdata and pc.
  - Word index = req_addr[ADDR_WIDTH+1:2].
  - Counter loads LATENCY-1 when LATENCY > 0.
- req_ready = 1 only in IDLE; req_valid seen in BUSY or DONE is not a new request.
- BUSY: counter decrements each cycle; the edge where counter = 0 enters DONE.
- Entry into DONE, at the same edge:
  - Store with valid address: for each lane i with byteen[i] = 1, mem[idx] lane i ← wdata lane i; other lanes unchanged.
  - resp_rdata ← merged word for a store, mem[idx] for a load.
  - resp_valid ← 1.
- Latency: resp_valid is high exactly LATENCY+1 cycles after the capture edge, for exactly one cycle.
- DONE always returns to IDLE next edge, clearing resp_valid and resp_err.
  - The earliest next capture is the edge after the IDLE cycle: back-to-back throughput is one request per LATENCY+2 cycles.
- Store with byteen = 4'b0000: no array change; response is normal with resp_rdata = current word.
- Out of range (req_addr[31:ADDR_WIDTH+2] ≠ 0, latched at capture):
  - No write.
  - resp_rdata = 0, resp_err = 1 with resp_valid.
- Read-after-write: a load following a store to the same word returns the merged data; there is no stale-read window.
- req_addr[1:0] ≠ 0 is not an error; lane selection comes solely from byteen.

Optional Feature:
- Macro: DM_RESPONDER_TRACE_EN.
- Defined: on each successful store commit (valid address, byteen ≠ 0), the block prints one simulation line: "@" PC ": *" addr " <= " data.
  - PC and data are 8-digit hex: data is the full post-merge word.
  - addr is the word-aligned byte address {upper zeros, idx, 2'b00}, also 8-digit hex.
  - No line is printed for loads, out-of-range requests, or zero-byteen stores.
- Undefined: no trace code is compiled; cycle behaviour is identical.

Test Plan:
- Reset, then load addr 0x0000_0010 (LATENCY=2) → req_ready drops at capture; resp_valid exactly 3 cycles later; resp_rdata = 0x0000_0000, resp_err = 0.
- Store addr 0x0000_0004, byteen 4'b1111, wdata 0xDEAD_BEEF; then store same addr, byteen 4'b0010, wdata 0x0000_5500; then load → second response 0xDEAD_55EF; load returns 0xDEAD_55EF.
- LATENCY=0 build: load captured at edge k → resp_valid high in the cycle after edge k; req_valid held continuously → next capture 2 edges after k.
- Store addr 0x0001_0000 (ADDR_WIDTH=12) → resp_err = 1, resp_rdata = 0; a following load of word index 0 returns its unchanged value.
- Store 0x1234_5678 to 0x0000_0008; assert reset one cycle after capture (BUSY) → no resp_valid; the load after reset returns 0.
- Trace build: store pc 0x0000_3008, addr 0x0000_0006, byteen 4'b1100, wdata 0xABCD_0000 → prints "@00003008: *00000004 <= abcd0000".
